// File: rtl/pe_pkg.sv
// Types and constants shared by the PE datapath stages (offset generator, accumulator).
package pe_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StAcc,
      StDone
   } pe_state_e;

   localparam logic [1:0] MODE_GEMM = 2'b00;
   localparam logic [1:0] MODE_DIV  = 2'b01;
   localparam logic [1:0] MODE_EXP  = 2'b10;
   localparam logic [1:0] MODE_LOG  = 2'b11;

endpackage

// File: rtl/pe_offset_acc_if.sv
// Operation, product-stream and result channels of the PE accumulation stage.
interface pe_offset_acc_if #(
   parameter int unsigned MUL_BW = 16,
   parameter int unsigned ACC_BW = 32,
   parameter int unsigned CNT_BW = 10
) ();

   logic                     start_i;
   logic [1:0]               gemm_uno_i;
   logic [CNT_BW-1:0]        len_i;
   logic signed [ACC_BW-1:0] offset_i;
   logic                     prod_valid_i;
   logic signed [MUL_BW-1:0] prod_i;
   logic                     prod_ready_o;
   logic                     res_valid_o;
   logic                     res_ready_i;
   logic signed [ACC_BW-1:0] res_o;
   logic [1:0]               res_mode_o;
   logic                     ovf_o;
   logic                     busy_o;

   modport master (
      output start_i, gemm_uno_i, len_i, offset_i, prod_valid_i, prod_i, res_ready_i,
      input  prod_ready_o, res_valid_o, res_o, res_mode_o, ovf_o, busy_o
   );

   modport slave (
      input  start_i, gemm_uno_i, len_i, offset_i, prod_valid_i, prod_i, res_ready_i,
      output prod_ready_o, res_valid_o, res_o, res_mode_o, ovf_o, busy_o
   );

endinterface

// File: rtl/sat_add.sv
// Signed accumulator + sign-extended product, clamped to the accumulator range.
module sat_add #(
   parameter int unsigned ACC_BW = 32,
   parameter int unsigned MUL_BW = 16
) (
   input  logic signed [ACC_BW-1:0] i_a,
   input  logic signed [MUL_BW-1:0] i_b,
   output logic signed [ACC_BW-1:0] o_sum,
   output logic                     o_sat
);

   logic [ACC_BW:0] w_wide;

   assign w_wide = {i_a[ACC_BW-1], i_a} + {{(ACC_BW + 1 - MUL_BW){i_b[MUL_BW-1]}}, i_b};

   // Top two bits disagree exactly when the true sum left the ACC_BW-bit range.
   always_comb begin
      o_sat = w_wide[ACC_BW] ^ w_wide[ACC_BW-1];
      o_sum = w_wide[ACC_BW-1:0];
      if (o_sat) begin
         o_sum = w_wide[ACC_BW] ? {1'b1, {(ACC_BW - 1){1'b0}}} : {1'b0, {(ACC_BW - 1){1'b1}}};
      end
   end

endmodule

// File: rtl/pe_offset_acc.sv
// PE accumulation stage: seeds with the generator offset, sums a counted product stream
// with saturation and hands the result downstream over valid/ready.
module pe_offset_acc
   import pe_pkg::*;
#(
   parameter int unsigned MUL_BW = 16,
   parameter int unsigned ACC_BW = 32,
   parameter int unsigned CNT_BW = 10
) (
   input logic            clk,
   input logic            rst_n,
   pe_offset_acc_if.slave bus
);

   pe_state_e                r_state;
   logic [CNT_BW-1:0]        r_len;
   logic [CNT_BW-1:0]        r_cnt;
   logic signed [ACC_BW-1:0] r_acc;
   logic [1:0]               r_mode;
   logic                     r_ovf;
   logic                     r_prod_ready;
   logic                     r_res_valid;
   logic                     r_busy;

   logic signed [ACC_BW-1:0] w_sum;
   logic                     w_sat;

   sat_add #(
      .ACC_BW(ACC_BW),
      .MUL_BW(MUL_BW)
   ) u_sat_add (
      .i_a  (r_acc),
      .i_b  (bus.prod_i),
      .o_sum(w_sum),
      .o_sat(w_sat)
   );

   // Handshake outputs are registered alongside the state so neither ready nor valid
   // depends combinationally on the opposite side of its channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_len        <= '0;
         r_cnt        <= '0;
         r_acc        <= '0;
         r_mode       <= '0;
         r_ovf        <= 1'b0;
         r_prod_ready <= 1'b0;
         r_res_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (bus.start_i) begin
                  r_mode  <= bus.gemm_uno_i;
                  r_len   <= bus.len_i;
                  r_busy  <= 1'b1;
                  r_state <= StLoad;
               end
            end
            StLoad: begin
               r_acc <= bus.offset_i;
               r_cnt <= r_len;
               r_ovf <= 1'b0;
               if (r_len != '0) begin
                  r_prod_ready <= 1'b1;
                  r_state      <= StAcc;
               end else begin
                  r_res_valid <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StAcc: begin
               if (bus.prod_valid_i) begin
                  r_acc <= w_sum;
                  r_cnt <= r_cnt - CNT_BW'(1);
                  r_ovf <= r_ovf | w_sat;
                  if (r_cnt == CNT_BW'(1)) begin
                     r_prod_ready <= 1'b0;
                     r_res_valid  <= 1'b1;
                     r_state      <= StDone;
                  end
               end
            end
            StDone: begin
               if (bus.res_ready_i) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.prod_ready_o = r_prod_ready;
   assign bus.res_valid_o  = r_res_valid;
   assign bus.res_o        = r_acc;
   assign bus.res_mode_o   = r_mode;
   assign bus.ovf_o        = r_ovf;
   assign bus.busy_o       = r_busy;

   a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(r_prod_ready && r_res_valid));
   a_cnt_nonzero_in_acc: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == StAcc) |-> (r_cnt != '0));

endmodule

// File: tb/tb_pe_offset_acc.sv
// Randomised bench for pe_offset_acc against a plain-arithmetic saturating-sum model.
module tb_pe_offset_acc;
   import pe_pkg::*;

   localparam int unsigned MUL_BW = 16;
   localparam int unsigned ACC_BW = 32;
   localparam int unsigned CNT_BW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pe_offset_acc_if #(.MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) bus ();

   pe_offset_acc #(
      .MUL_BW(MUL_BW),
      .ACC_BW(ACC_BW),
      .CNT_BW(CNT_BW)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic signed [MUL_BW-1:0] prods[$];

   // Observations gathered by run_op for the calling test to judge.
   logic signed [ACC_BW-1:0] o_res;
   logic [1:0]               o_mode;
   logic                     o_ovf;
   int                       o_valid_cyc;
   int                       o_hs;
   int                       o_hold_bad;
   bit                       o_timeout;
   bit                       o_early_ready;
   bit                       o_any_ready;
   bit                       o_busy_bad;
   bit                       o_post_busy;
   bit                       o_post_valid;

   // Reference: offset plus products, clamped to the signed range after every step.
   function automatic longint model_acc(input longint offset, input int n, output bit ovf);
      longint acc = offset;
      longint mx  = (longint'(1) <<< (ACC_BW - 1)) - 1;
      longint mn  = -(longint'(1) <<< (ACC_BW - 1));
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         acc += longint'(prods[i]);
         if (acc > mx) begin
            acc = mx;
            ovf = 1'b1;
         end else if (acc < mn) begin
            acc = mn;
            ovf = 1'b1;
         end
      end
      return acc;
   endfunction

   // Called at a negedge (cycle T); returns at the negedge of the first IDLE cycle.
   // gap < 0 gives random gaps of 0..3 idle cycles after each product.
   task automatic run_op(input logic [1:0] mode, input int len,
                         input logic signed [ACC_BW-1:0] offset, input int gap,
                         input int ready_wait);
      int k = 0;
      int idx = 0;
      int wait_gap = 0;
      o_hs = 0; o_hold_bad = 0; o_timeout = 0; o_early_ready = 0; o_any_ready = 0;
      o_busy_bad = 0; o_valid_cyc = -1;
      bus.start_i = 1'b1;
      bus.gemm_uno_i = mode;
      bus.len_i = CNT_BW'(len);
      bus.offset_i = $urandom;
      bus.res_ready_i = 1'b0;
      while (!bus.res_valid_o && k < 300) begin
         if (k == 1) begin
            bus.start_i = 1'b0;
            bus.len_i = CNT_BW'($urandom);
            bus.gemm_uno_i = 2'($urandom);
            bus.offset_i = offset;
         end else if (k > 1) begin
            bus.offset_i = $urandom;
         end
         if (k < 2 && bus.prod_ready_o) o_early_ready = 1'b1;
         if (bus.prod_ready_o) o_any_ready = 1'b1;
         if (k >= 1 && !bus.busy_o) o_busy_bad = 1'b1;
         if (idx < len && wait_gap == 0) begin
            bus.prod_valid_i = 1'b1;
            bus.prod_i = prods[idx];
         end else begin
            bus.prod_valid_i = 1'b0;
            bus.prod_i = MUL_BW'($urandom);
         end
         if (bus.prod_valid_i && bus.prod_ready_o) begin
            idx++;
            o_hs++;
            wait_gap = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         end else if (!bus.prod_valid_i && wait_gap > 0) begin
            wait_gap--;
         end
         @(negedge clk);
         k++;
      end
      bus.prod_valid_i = 1'b0;
      if (!bus.res_valid_o) begin
         o_timeout = 1'b1;
         return;
      end
      o_valid_cyc = k;
      o_res = bus.res_o;
      o_mode = bus.res_mode_o;
      o_ovf = bus.ovf_o;
      for (int w = 0; w < ready_wait; w++) begin
         bus.start_i = 1'b1;
         bus.len_i = CNT_BW'($urandom);
         @(negedge clk);
         if (!bus.res_valid_o || bus.res_o !== o_res || bus.res_mode_o !== o_mode ||
             bus.ovf_o !== o_ovf || bus.prod_ready_o) o_hold_bad++;
      end
      // start_i coinciding with the result handshake must be dropped.
      bus.res_ready_i = 1'b1;
      bus.start_i = 1'b1;
      bus.len_i = CNT_BW'($urandom);
      @(negedge clk);
      bus.res_ready_i = 1'b0;
      bus.start_i = 1'b0;
      o_post_busy = bus.busy_o;
      o_post_valid = bus.res_valid_o;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      if (bus.prod_ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_prod_ready: got %b want 0", bus.prod_ready_o); end
      if (bus.res_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid_o); end
      if (bus.res_o !== '0) begin n_errors++; $display("FAIL reset_res: got %0h want 0", bus.res_o); end
      if (bus.res_mode_o !== 2'b00) begin n_errors++; $display("FAIL reset_mode: got %b want 00", bus.res_mode_o); end
      if (bus.ovf_o !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_o); end
      if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      n_checks += 6;
      rst_n = 1'b1;
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release_idle: busy %b valid %b want 0 0", bus.busy_o, bus.res_valid_o);
      end
      n_checks++;
   endtask

   task automatic test_gemm_basic();
      prods = '{16'sd3, -16'sd1, 16'sd10, 16'sd5};
      run_op(MODE_GEMM, 4, 32'sd0, 0, 0);
      if (o_res !== 32'sd17) begin n_errors++; $display("FAIL gemm_res: got %0d want 17", o_res); end
      if (o_ovf !== 1'b0) begin n_errors++; $display("FAIL gemm_ovf: got %b want 0", o_ovf); end
      if (o_mode !== MODE_GEMM) begin n_errors++; $display("FAIL gemm_mode: got %b want 00", o_mode); end
      if (o_valid_cyc !== 6) begin n_errors++; $display("FAIL gemm_latency: got T+%0d want T+6", o_valid_cyc); end
      if (o_early_ready !== 1'b0) begin n_errors++; $display("FAIL gemm_early_ready: got %b want 0", o_early_ready); end
      if (o_busy_bad !== 1'b0) begin n_errors++; $display("FAIL gemm_busy: dropped busy %b want 0", o_busy_bad); end
      if (o_post_busy !== 1'b0 || o_post_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL gemm_post_idle: busy %b valid %b want 0 0", o_post_busy, o_post_valid);
      end
      n_checks += 7;
   endtask

   task automatic test_log_gapped();
      prods = '{16'sh0010, 16'sh0020};
      run_op(MODE_LOG, 2, 32'sh1000, 2, 0);
      if (o_res !== 32'sh1030) begin n_errors++; $display("FAIL log_res: got %0h want 1030", o_res); end
      if (o_mode !== MODE_LOG) begin n_errors++; $display("FAIL log_mode: got %b want 11", o_mode); end
      if (o_hs !== 2) begin n_errors++; $display("FAIL log_handshakes: got %0d want 2", o_hs); end
      if (o_valid_cyc !== 6) begin n_errors++; $display("FAIL log_latency: got T+%0d want T+6", o_valid_cyc); end
      n_checks += 4;
   endtask

   task automatic test_len_zero();
      prods = {};
      repeat (2) @(negedge clk);
      run_op(MODE_EXP, 0, 32'sh2B80, 0, 0);
      if (o_res !== 32'sh2B80) begin n_errors++; $display("FAIL len0_res: got %0h want 2b80", o_res); end
      if (o_valid_cyc !== 2) begin n_errors++; $display("FAIL len0_latency: got T+%0d want T+2", o_valid_cyc); end
      if (o_any_ready !== 1'b0) begin n_errors++; $display("FAIL len0_ready_pulse: got %b want 0", o_any_ready); end
      n_checks += 3;
   endtask

   task automatic test_saturation();
      prods = '{16'sh7FFF, -16'sd1};
      run_op(MODE_GEMM, 2, 32'sh7FFFFFF0, 0, 0);
      if (o_res !== 32'sh7FFFFFFE) begin n_errors++; $display("FAIL sat_pos_res: got %0h want 7ffffffe", o_res); end
      if (o_ovf !== 1'b1) begin n_errors++; $display("FAIL sat_pos_ovf: got %b want 1", o_ovf); end
      prods = '{-16'sd16};
      run_op(MODE_DIV, 1, 32'sh80000005, 0, 0);
      if (o_res !== 32'sh80000000) begin n_errors++; $display("FAIL sat_neg_res: got %0h want 80000000", o_res); end
      if (o_ovf !== 1'b1) begin n_errors++; $display("FAIL sat_neg_ovf: got %b want 1", o_ovf); end
      prods = '{16'sd1};
      run_op(MODE_GEMM, 1, 32'sd0, 0, 0);
      if (o_ovf !== 1'b0) begin n_errors++; $display("FAIL sat_ovf_cleared: got %b want 0", o_ovf); end
      n_checks += 5;
   endtask

   task automatic test_back_to_back();
      logic signed [ACC_BW-1:0] off;
      longint exp_l;
      bit exp_ovf;
      prods = {};
      repeat (3) prods.push_back(MUL_BW'($urandom));
      off = $urandom;
      exp_l = model_acc(longint'(off), 3, exp_ovf);
      run_op(MODE_EXP, 3, off, 0, 5);
      if (o_res !== exp_l[ACC_BW-1:0]) begin n_errors++; $display("FAIL bp_res: got %0h want %0h", o_res, exp_l[ACC_BW-1:0]); end
      if (o_hold_bad !== 0) begin n_errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", o_hold_bad); end
      if (o_post_busy !== 1'b0) begin n_errors++; $display("FAIL bp_start_ignored: busy %b want 0", o_post_busy); end
      // Next op starts in the first IDLE cycle after the handshake.
      prods = '{16'sd100, -16'sd40};
      run_op(MODE_LOG, 2, 32'sd5, 0, 0);
      if (o_res !== 32'sd65) begin n_errors++; $display("FAIL b2b_res: got %0d want 65", o_res); end
      if (o_valid_cyc !== 4) begin n_errors++; $display("FAIL b2b_latency: got T+%0d want T+4", o_valid_cyc); end
      if (o_mode !== MODE_LOG) begin n_errors++; $display("FAIL b2b_mode: got %b want 11", o_mode); end
      n_checks += 6;
   endtask

   task automatic test_reset_mid_op();
      prods = {};
      repeat (8) prods.push_back(MUL_BW'($urandom_range(1, 1000)));
      @(negedge clk);
      bus.start_i = 1'b1; bus.gemm_uno_i = MODE_LOG; bus.len_i = CNT_BW'(8);
      @(negedge clk);
      bus.start_i = 1'b0; bus.offset_i = 32'sd123;
      @(negedge clk);
      bus.prod_valid_i = 1'b1; bus.prod_i = prods[0];
      @(negedge clk);
      bus.prod_i = prods[1];
      @(negedge clk);
      bus.prod_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      if (bus.prod_ready_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_ctrl: ready %b valid %b busy %b want 0 0 0",
                  bus.prod_ready_o, bus.res_valid_o, bus.busy_o);
      end
      if (bus.res_o !== '0 || bus.res_mode_o !== 2'b00 || bus.ovf_o !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_data: res %0h mode %b ovf %b want 0 00 0",
                  bus.res_o, bus.res_mode_o, bus.ovf_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_no_result: busy %b valid %b want 0 0", bus.busy_o, bus.res_valid_o);
      end
      prods = '{16'sd7};
      run_op(MODE_GEMM, 1, 32'sd0, 0, 0);
      if (o_res !== 32'sd7) begin n_errors++; $display("FAIL midrst_next_res: got %0d want 7", o_res); end
      n_checks += 4;
   endtask

   task automatic test_random();
      logic signed [ACC_BW-1:0] off;
      longint exp_l;
      bit exp_ovf;
      int len, gap;
      logic [1:0] mode;
      for (int it = 0; it < 30; it++) begin
         len = $urandom_range(0, 12);
         gap = ($urandom_range(0, 1) == 0) ? 0 : -1;
         mode = 2'($urandom);
         prods = {};
         repeat (len) prods.push_back(MUL_BW'($urandom));
         case ($urandom_range(0, 3))
            0: off = $urandom;
            1: off = 32'sh7FFF0000 + ACC_BW'($urandom_range(0, 16'hFFFF));
            2: off = 32'sh80010000 - ACC_BW'($urandom_range(0, 16'hFFFF));
            default: off = 32'sd0;
         endcase
         exp_l = model_acc(longint'(off), len, exp_ovf);
         run_op(mode, len, off, gap, $urandom_range(0, 3));
         if (o_timeout) begin n_errors++; $display("FAIL rnd%0d_timeout: no result want result", it); end
         if (o_res !== exp_l[ACC_BW-1:0]) begin
            n_errors++;
            $display("FAIL rnd%0d_res: got %0h want %0h", it, o_res, exp_l[ACC_BW-1:0]);
         end
         if (o_ovf !== exp_ovf) begin n_errors++; $display("FAIL rnd%0d_ovf: got %b want %b", it, o_ovf, exp_ovf); end
         if (o_mode !== mode) begin n_errors++; $display("FAIL rnd%0d_mode: got %b want %b", it, o_mode, mode); end
         if (o_hs !== len) begin n_errors++; $display("FAIL rnd%0d_handshakes: got %0d want %0d", it, o_hs, len); end
         if (o_hold_bad !== 0) begin n_errors++; $display("FAIL rnd%0d_hold: got %0d want 0", it, o_hold_bad); end
         n_checks += 6;
         if (gap == 0) begin
            if (o_valid_cyc !== len + 2) begin
               n_errors++;
               $display("FAIL rnd%0d_latency: got T+%0d want T+%0d", it, o_valid_cyc, len + 2);
            end
            n_checks++;
         end
         if (o_timeout) break;
      end
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.gemm_uno_i = 2'b00;
      bus.len_i = '0;
      bus.offset_i = '0;
      bus.prod_valid_i = 1'b0;
      bus.prod_i = '0;
      bus.res_ready_i = 1'b0;
      test_reset();
      test_gemm_basic();
      test_log_gapped();
      test_len_zero();
      test_saturation();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
